// File: rtl/pwm_fade_ctrl_if.sv
// Register bus between the system side and the PWM fade controller.
// Single-cycle write/read strobes; readdata is registered by the slave.
interface pwm_fade_ctrl_if #(
    parameter int n = 32
);
    logic [2:0]   address;
    logic         write;
    logic [n-1:0] writedata;
    logic         read;
    logic [n-1:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller: bus-programmed period/duty, duty ramped toward a target on PWM period boundaries.
// Reads return one cycle after the strobe; no backpressure, every bus access completes in one cycle.
module pwm_fade_ctrl #(
    parameter int n          = 32,
    parameter int m          = 4,
    parameter int DEF_PERIOD = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    pwm_fade_ctrl_if.slave        bus,
    output logic                  irq,
    output logic [n:0]            pwm_period,
    output logic [n-1:0]          pwm_duty,
    output logic [m-1:0]          pwm_byteenable,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_JUMP, S_RAMP, S_DONE} state_t;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PERIOD   = 3'd1;
    localparam logic [2:0] A_TARGET   = 3'd2;
    localparam logic [2:0] A_STEP     = 3'd3;
    localparam logic [2:0] A_INTERVAL = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;
    localparam logic [2:0] A_DUTY     = 3'd6;

    localparam logic [n:0]   ONE_P = (n+1)'(1);
    localparam logic [n:0]   DEF_P = (n+1)'(DEF_PERIOD);
    localparam logic [n-1:0] ONE_N = n'(1);

    state_t       state;
    logic [2:0]   ctrl_q;
    logic [n:0]   period_sh;
    logic [n-1:0] target_q;
    logic [n-1:0] step_q;
    logic [n-1:0] interval_q;
    logic         done_q;
    logic [n:0]   cnt;
    logic [n-1:0] ivl_cnt;

    logic en, fade_en, irq_en;
    logic wr_ctrl, wr_period, wr_target, wr_step, wr_interval, wr_status;
    logic [n:0]   eff_period;
    logic [n-1:0] eff_step, eff_interval, step_nxt, rd_mux;
    logic boundary, ivl_last;

    assign en      = ctrl_q[0];
    assign fade_en = ctrl_q[1];
    assign irq_en  = ctrl_q[2];

    assign wr_ctrl     = bus.write && (bus.address == A_CTRL);
    assign wr_period   = bus.write && (bus.address == A_PERIOD);
    assign wr_target   = bus.write && (bus.address == A_TARGET);
    assign wr_step     = bus.write && (bus.address == A_STEP);
    assign wr_interval = bus.write && (bus.address == A_INTERVAL);
    assign wr_status   = bus.write && (bus.address == A_STATUS);

    // Zero-valued period/step/interval behave as 1 so the timebase never stalls.
    always_comb begin
        eff_period   = (pwm_period == '0) ? ONE_P : pwm_period;
        eff_step     = (step_q == '0) ? ONE_N : step_q;
        eff_interval = (interval_q == '0) ? ONE_N : interval_q;
        boundary     = en && (cnt == eff_period);
        ivl_last     = (ivl_cnt >= eff_interval - ONE_N);

        // Compare the remaining distance first so the step never overshoots or wraps.
        step_nxt = target_q;
        if (target_q > pwm_duty) begin
            if ((target_q - pwm_duty) > eff_step)
                step_nxt = pwm_duty + eff_step;
        end else if ((pwm_duty - target_q) > eff_step) begin
            step_nxt = pwm_duty - eff_step;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_CTRL:     rd_mux = {{(n-3){1'b0}}, ctrl_q};
            A_PERIOD:   rd_mux = period_sh[n-1:0];
            A_TARGET:   rd_mux = target_q;
            A_STEP:     rd_mux = step_q;
            A_INTERVAL: rd_mux = interval_q;
            A_STATUS:   rd_mux = {{(n-2){1'b0}}, done_q, busy};
            A_DUTY:     rd_mux = pwm_duty;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q       <= '0;
            period_sh    <= DEF_P;
            target_q     <= '0;
            step_q       <= '0;
            interval_q   <= ONE_N;
            done_q       <= 1'b0;
            pwm_period   <= DEF_P;
            cnt          <= ONE_P;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_ctrl)     ctrl_q     <= bus.writedata[2:0];
            if (wr_period)   period_sh  <= {1'b0, bus.writedata};
            if (wr_target)   target_q   <= bus.writedata;
            if (wr_step)     step_q     <= bus.writedata;
            if (wr_interval) interval_q <= bus.writedata;

            if (en && (state == S_DONE))
                done_q <= 1'b1;
            else if (wr_status && bus.writedata[1])
                done_q <= 1'b0;
            irq <= done_q & irq_en;

            // The shadow seen here is pre-write, so a write on a boundary waits for the next one.
            if (!en)
                pwm_period <= wr_period ? {1'b0, bus.writedata} : period_sh;
            else if (boundary)
                pwm_period <= period_sh;

            if (!en || boundary)
                cnt <= ONE_P;
            else
                cnt <= cnt + ONE_P;

            if (bus.read)
                bus.readdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            pwm_duty       <= '0;
            pwm_byteenable <= '0;
            busy           <= 1'b0;
            ivl_cnt        <= '0;
        end else begin
            pwm_byteenable <= '0;
            if (en) begin
                case (state)
                    S_IDLE: begin
                        if (target_q != pwm_duty) begin
                            state   <= fade_en ? S_RAMP : S_JUMP;
                            busy    <= 1'b1;
                            ivl_cnt <= '0;
                        end
                    end
                    S_JUMP, S_RAMP: begin
                        if (wr_target && (bus.writedata == pwm_duty)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else if (boundary) begin
                            if ((state == S_JUMP) || !fade_en) begin
                                pwm_duty       <= target_q;
                                pwm_byteenable <= '1;
                                state          <= S_DONE;
                                busy           <= 1'b0;
                            end else if (ivl_last) begin
                                pwm_duty       <= step_nxt;
                                pwm_byteenable <= '1;
                                ivl_cnt        <= '0;
                                if (step_nxt == target_q) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                ivl_cnt <= ivl_cnt + ONE_N;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: register reset values, jump, ramp up/down, retarget, period shadowing, async reset.
module tb_pwm_fade_ctrl;
    localparam int N = 32;
    localparam int M = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          irq;
    logic [N:0]    pwm_period;
    logic [N-1:0]  pwm_duty;
    logic [M-1:0]  pwm_byteenable;
    logic          busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    pwm_fade_ctrl_if #(.n(N)) bus ();

    pwm_fade_ctrl #(.n(N), .m(M), .DEF_PERIOD(1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .irq            (irq),
        .pwm_period     (pwm_period),
        .pwm_duty       (pwm_duty),
        .pwm_byteenable (pwm_byteenable),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [N-1:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [N-1:0] d);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [N-1:0] exp);
        logic [N-1:0] d;
        bus_rd(a, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    // Waits for a byteenable pulse; returns the cycle stamp of the update edge and the new duty.
    task automatic wait_load(input string tag, input int max, output int t, output logic [N-1:0] d);
        t = -1; d = '0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (pwm_byteenable != '0) begin
                t = cyc; d = pwm_duty;
                break;
            end
        end
        if (t < 0) begin
            chk({tag, "_timeout"}, 64'(pwm_byteenable), 64'hF);
        end else begin
            chk({tag, "_be"}, 64'(pwm_byteenable), 64'hF);
            @(negedge clk);
            chk({tag, "_be_pulse"}, 64'(pwm_byteenable), 64'h0);
            chk({tag, "_duty_hold"}, 64'(pwm_duty), 64'(d));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.write = 1'b0; bus.read = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int t, t0, prev;
        logic [N-1:0] d;
        logic be_seen;
        int exp_up [4] = '{3, 6, 9, 10};
        int exp_dn [3] = '{6, 2, 0};

        bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_period", 64'(pwm_period), 64'd1000);
        chk("rst_duty",   64'(pwm_duty),   64'd0);
        chk("rst_irq",    64'(irq),        64'd0);
        chk("rst_busy",   64'(busy),       64'd0);
        chk("rst_rdata",  64'(bus.readdata), 64'd0);
        rd_chk("rst_ctrl",     3'd0, 32'd0);
        rd_chk("rst_period_r", 3'd1, 32'd1000);
        rd_chk("rst_target",   3'd2, 32'd0);
        rd_chk("rst_step",     3'd3, 32'd0);
        rd_chk("rst_interval", 3'd4, 32'd1);
        rd_chk("rst_status",   3'd5, 32'd0);
        rd_chk("rst_duty_r",   3'd6, 32'd0);
        rd_chk("rst_addr7",    3'd7, 32'd0);
        be_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            be_seen = be_seen | (|pwm_byteenable);
        end
        chk("rst_be_quiet", 64'(be_seen), 64'd0);

        // Jump: EN=0 copies PERIOD immediately and freezes the FSM
        bus_wr(3'd1, 32'd10);
        bus_wr(3'd2, 32'd7);
        chk("jmp_period_imm", 64'(pwm_period), 64'd10);
        chk("jmp_frozen",     64'(pwm_duty),   64'd0);
        bus_wr(3'd0, 32'd1);
        t0 = cyc;
        wait_load("jmp", 40, t, d);
        chk("jmp_duty", 64'(d), 64'd7);
        chk("jmp_lat",  64'(t - t0), 64'd10);
        rd_chk("jmp_status", 3'd5, 32'd2);
        rd_chk("jmp_duty_r", 3'd6, 32'd7);
        chk("jmp_irq", 64'(irq), 64'd0);

        // Ramp up from 0: 3, 6, 9, 10 every 8 cycles
        do_reset();
        bus_wr(3'd1, 32'd4);
        bus_wr(3'd3, 32'd3);
        bus_wr(3'd4, 32'd2);
        bus_wr(3'd2, 32'd10);
        bus_wr(3'd0, 32'd7);
        t0 = cyc;
        prev = t0;
        foreach (exp_up[i]) begin
            wait_load("up", 40, t, d);
            chk("up_duty", 64'(d), 64'(exp_up[i]));
            chk("up_gap",  64'(t - prev), 64'd8);
            prev = t;
        end
        for (int i = 0; i < 10 && !irq; i++) @(negedge clk);
        chk("up_irq",  64'(irq),  64'd1);
        chk("up_busy", 64'(busy), 64'd0);
        bus_wr(3'd5, 32'd2);
        @(negedge clk);
        chk("up_irq_clr", 64'(irq), 64'd0);
        rd_chk("up_status_clr", 3'd5, 32'd0);

        // Ramp down 10 -> 0 with STEP=4: 6, 2, 0 (clamped)
        bus_wr(3'd3, 32'd4);
        bus_wr(3'd2, 32'd0);
        foreach (exp_dn[i]) begin
            wait_load("dn", 40, t, d);
            chk("dn_duty", 64'(d), 64'(exp_dn[i]));
        end
        rd_chk("dn_status", 3'd5, 32'd2);
        bus_wr(3'd5, 32'd2);

        // Retarget mid-ramp to the current duty
        bus_wr(3'd3, 32'd3);
        bus_wr(3'd2, 32'd20);
        wait_load("rt1", 40, t, d);
        chk("rt1_duty", 64'(d), 64'd3);
        wait_load("rt2", 40, t, d);
        chk("rt2_duty", 64'(d), 64'd6);
        chk("rt_busy_on", 64'(busy), 64'd1);
        bus_wr(3'd2, 32'd6);
        @(negedge clk);
        chk("rt_busy_off", 64'(busy), 64'd0);
        be_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            be_seen = be_seen | (|pwm_byteenable);
        end
        chk("rt_no_load", 64'(be_seen), 64'd0);
        chk("rt_duty",    64'(pwm_duty), 64'd6);
        rd_chk("rt_status", 3'd5, 32'd2);
        bus_wr(3'd5, 32'd2);

        // Period shadowing during a ramp with one step per boundary
        bus_wr(3'd4, 32'd1);
        bus_wr(3'd2, 32'd20);
        wait_load("pr1", 40, t, d);
        chk("pr1_duty", 64'(d), 64'd9);
        bus_wr(3'd1, 32'd20);
        chk("pr_period_held", 64'(pwm_period), 64'd4);
        wait_load("pr2", 40, t, d);
        chk("pr2_duty",   64'(d), 64'd12);
        chk("pr_period_new", 64'(pwm_period), 64'd20);
        prev = t;
        wait_load("pr3", 40, t, d);
        chk("pr3_duty", 64'(d), 64'd15);
        chk("pr3_gap",  64'(t - prev), 64'd20);

        // Asynchronous reset mid-ramp
        #2;
        reset = 1'b1;
        #1;
        chk("ar_period", 64'(pwm_period), 64'd1000);
        chk("ar_duty",   64'(pwm_duty),   64'd0);
        chk("ar_be",     64'(pwm_byteenable), 64'd0);
        chk("ar_irq",    64'(irq),  64'd0);
        chk("ar_busy",   64'(busy), 64'd0);
        chk("ar_rdata",  64'(bus.readdata), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        be_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            be_seen = be_seen | (|pwm_byteenable);
        end
        chk("ar_be_quiet", 64'(be_seen), 64'd0);
        chk("ar_duty_post", 64'(pwm_duty), 64'd0);
        rd_chk("ar_ctrl", 3'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
